program_loader: RTL

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader_pkg.sv | 35 +++
 rtl/program_loader_word_assembler.sv | 40 ++++
 rtl/program_loader.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/program_loader_pkg.sv
// ---------------------------------------------------------------------------
// program_loader_pkg
//   Shared debug-port definitions used by the UART program loader:
//   loader FSM state encoding, UART command codes, response bytes and
//   word/count sizing.
//   No ports (package).
// ---------------------------------------------------------------------------
package program_loader_pkg;

   // Loader FSM states
   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_WAIT_COUNT = 3'd1,
      ST_RECV       = 3'd2,
      ST_WRITE      = 3'd3,
      ST_ACK        = 3'd4
   } loader_state_t;

   // UART debug command codes
   localparam logic [7:0] CMD_LOAD_CODE = 8'h07;   // open a program load

   // Response bytes sent back over the UART
   localparam logic [7:0] RESP_READY = 8'h52;      // 'R'
   localparam logic [7:0] RESP_ERROR = 8'h45;      // 'E'

   // Sizing
   localparam int WORD_BYTES  = 4;
   localparam int COUNT_WIDTH = 7;                 // holds 0..127 words

   // Response byte for a finished load
   function automatic logic [7:0] resp_byte(input logic err);
      return err ? RESP_ERROR : RESP_READY;
   endfunction

endpackage : program_loader_pkg

// File: rtl/program_loader_word_assembler.sv
// ---------------------------------------------------------------------------
// word_assembler
//   Little-endian byte-to-word shift assembler. Each accepted byte enters at
//   the top and older bytes move down, so after four shifts the first byte
//   sits in bits 7:0 and the fourth in bits 31:24. o_word_next shows the word
//   as it would be if i_byte were shifted in now, which lets the parent
//   capture a complete word in the same cycle as the fourth byte.
//
//   Ports:
//     i_clk        clock, rising edge
//     i_rst        synchronous active-high reset
//     i_clear      empty the shift register (start of a new load)
//     i_shift      shift i_byte in this cycle
//     i_byte       byte to shift in
//     o_word_next  {i_byte, previous three bytes}
// ---------------------------------------------------------------------------
module word_assembler (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_clear,
   input  logic        i_shift,
   input  logic [7:0]  i_byte,
   output logic [31:0] o_word_next
);

   logic [31:0] shift_q;

   assign o_word_next = {i_byte, shift_q[31:8]};

   always_ff @(posedge i_clk) begin
      // NOTE: sequential state is always written with <= so every register
      // samples pre-edge values regardless of statement order.
      if (i_rst || i_clear) begin
         shift_q <= '0;
      end else if (i_shift) begin
         shift_q <= o_word_next;
      end
   end

endmodule : word_assembler

// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader
//   Receives a program over the UART debug link and writes it into
//   instruction memory. Protocol: CMD_LOAD, count N, then 4*N bytes
//   (little-endian words). Answers 'R' on success or 'E' when N is out of
//   range; the CPU is held (o_loading) for the whole transaction.
//
//   Ports:
//     i_clk, i_rst            clock / synchronous active-high reset
//     i_rx_data, i_rx_valid   received byte and its one-cycle strobe
//     i_tx_busy               transmitter occupied
//     o_tx_data, o_tx_start   response byte and its one-cycle send request
//     o_imem_we/addr/data     instruction-memory write port (byte address)
//     o_loading               load in progress, CPU held
//     o_done                  one-cycle pulse on successful completion
//     o_count                 words written by the last load
//     o_err                   sticky out-of-range flag, cleared by next load
// ---------------------------------------------------------------------------
module program_loader
   import program_loader_pkg::*;
#(
   parameter int          ADDR_WIDTH      = 32,
   parameter int          MAX_INSTRUCTION = 64,   // must stay below 128
   parameter logic [7:0]  CMD_LOAD        = CMD_LOAD_CODE
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic [7:0]             i_rx_data,
   input  logic                   i_rx_valid,
   input  logic                   i_tx_busy,
   output logic [7:0]             o_tx_data,
   output logic                   o_tx_start,
   output logic                   o_imem_we,
   output logic [ADDR_WIDTH-1:0]  o_imem_addr,
   output logic [31:0]            o_imem_data,
   output logic                   o_loading,
   output logic                   o_done,
   output logic [COUNT_WIDTH-1:0] o_count,
   output logic                   o_err
);

   loader_state_t          state;
   logic [COUNT_WIDTH-1:0] n_words;     // words requested by this load
   logic [COUNT_WIDTH-1:0] word_idx;    // words already written
   logic [1:0]             byte_idx;    // bytes of the current word received

   logic [COUNT_WIDTH-1:0] word_idx_inc;
   logic                   last_word;
   logic                   asm_shift;
   logic                   asm_clear;
   logic [31:0]            asm_word;
   logic [ADDR_WIDTH-1:0]  word_addr;

   assign word_idx_inc = word_idx + COUNT_WIDTH'(1);
   assign last_word    = (word_idx_inc == n_words);
   assign word_addr    = ADDR_WIDTH'({word_idx, 2'b00});

   // A byte is taken into the assembler in RECV, and also in WRITE when
   // another word follows, so a byte strobed during the write cycle becomes
   // byte 0 of the next word instead of being dropped.
   assign asm_shift = i_rx_valid &&
                      ((state == ST_RECV) || (state == ST_WRITE && !last_word));
   assign asm_clear = i_rx_valid && (state == ST_WAIT_COUNT);

   word_assembler u_word_assembler (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_clear     (asm_clear),
      .i_shift     (asm_shift),
      .i_byte      (i_rx_data),
      .o_word_next (asm_word)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state       <= ST_IDLE;
         n_words     <= '0;
         word_idx    <= '0;
         byte_idx    <= '0;
         o_tx_data   <= '0;
         o_tx_start  <= 1'b0;
         o_imem_we   <= 1'b0;
         o_imem_addr <= '0;
         o_imem_data <= '0;
         o_loading   <= 1'b0;
         o_done      <= 1'b0;
         o_count     <= '0;
         o_err       <= 1'b0;
      end else begin
         // NOTE: strobe outputs default low every cycle; the state that
         // fires them sets them for exactly one cycle.
         o_imem_we  <= 1'b0;
         o_tx_start <= 1'b0;
         o_done     <= 1'b0;

         unique case (state)
            ST_IDLE: begin
               if (i_rx_valid && i_rx_data == CMD_LOAD) begin
                  o_err     <= 1'b0;
                  o_count   <= '0;
                  o_loading <= 1'b1;
                  state     <= ST_WAIT_COUNT;
               end
            end

            ST_WAIT_COUNT: begin
               if (i_rx_valid) begin
                  if (i_rx_data == 8'd0) begin
                     state <= ST_ACK;
                  end else if (int'(i_rx_data) > MAX_INSTRUCTION) begin
                     o_err <= 1'b1;
                     state <= ST_ACK;
                  end else begin
                     n_words  <= i_rx_data[COUNT_WIDTH-1:0];
                     word_idx <= '0;
                     byte_idx <= '0;
                     state    <= ST_RECV;
                  end
               end
            end

            ST_RECV: begin
               if (i_rx_valid) begin
                  if (byte_idx == 2'(WORD_BYTES - 1)) begin
                     // Fourth byte: present the full word during WRITE.
                     byte_idx    <= '0;
                     o_imem_we   <= 1'b1;
                     o_imem_addr <= word_addr;
                     o_imem_data <= asm_word;
                     state       <= ST_WRITE;
                  end else begin
                     byte_idx <= byte_idx + 2'd1;
                  end
               end
            end

            ST_WRITE: begin
               word_idx <= word_idx_inc;
               o_count  <= o_count + COUNT_WIDTH'(1);
               if (last_word) begin
                  state <= ST_ACK;
               end else begin
                  byte_idx <= i_rx_valid ? 2'd1 : 2'd0;
                  state    <= ST_RECV;
               end
            end

            ST_ACK: begin
               if (!i_tx_busy) begin
                  o_tx_start <= 1'b1;
                  o_tx_data  <= resp_byte(o_err);
                  o_done     <= !o_err;
                  o_loading  <= 1'b0;
                  state      <= ST_IDLE;
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule : program_loader
